// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE      = 2'd0;
    localparam arb_state_t ARB_BUSY_IF   = 2'd1;
    localparam arb_state_t ARB_BUSY_DATA = 2'd2;

    localparam int XLEN_DEFAULT       = 32;
    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data handshakes and the shared memory bus, seen from the arbiter (master)
// and from the core plus bus wrapper (slave).
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic            ifReq;
    logic [XLEN-1:0] ifAddr;
    logic            ifFlush;
    logic [XLEN-1:0] ifInstr;
    logic            ifValid;

    logic            dataReq;
    logic            dataWe;
    logic [XLEN-1:0] dataAddr;
    logic [XLEN-1:0] dataWdata;
    logic [XLEN-1:0] dataRdata;
    logic            dataValid;

    logic            memReq;
    logic            memWe;
    logic [XLEN-1:0] memAddr;
    logic [XLEN-1:0] memWdata;
    logic [XLEN-1:0] memRdata;
    logic            memAck;

    modport master (
        input  ifReq, ifAddr, ifFlush, dataReq, dataWe, dataAddr, dataWdata, memRdata, memAck,
        output ifInstr, ifValid, dataRdata, dataValid, memReq, memWe, memAddr, memWdata
    );

    modport slave (
        output ifReq, ifAddr, ifFlush, dataReq, dataWe, dataAddr, dataWdata, memRdata, memAck,
        input  ifInstr, ifValid, dataRdata, dataValid, memReq, memWe, memAddr, memWdata
    );

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of data grants that overtook a waiting fetch.
module arb_starve_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(STARVE_MAX);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

    assign at_max = (count == MAX_COUNT);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory bus between instruction fetch and load/store,
// data first, with a starvation guard that eventually forces a waiting fetch through.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);

    arb_state_t      state;
    logic            flush_q;
    logic            if_valid_q;
    logic            data_valid_q;
    logic [XLEN-1:0] if_instr_q;
    logic [XLEN-1:0] data_rdata_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;

    logic if_valid_out;
    logic if_pend;
    logic data_pend;
    logic grant_data;
    logic grant_if;
    logic at_max;

    // A requester seeing its valid this cycle is still holding the request it just finished.
    assign if_valid_out = if_valid_q & ~bus.ifFlush;
    assign if_pend      = bus.ifReq & ~if_valid_out;
    assign data_pend    = bus.dataReq & ~data_valid_q;
    assign grant_data   = (state == ARB_IDLE) & data_pend & ~(if_pend & at_max);
    assign grant_if     = (state == ARB_IDLE) & if_pend & ~grant_data;

    arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_data & if_pend),
        .clr   (grant_if),
        .at_max(at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARB_IDLE;
            flush_q      <= 1'b0;
            if_valid_q   <= 1'b0;
            data_valid_q <= 1'b0;
            if_instr_q   <= '0;
            data_rdata_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            if_valid_q   <= 1'b0;
            data_valid_q <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_data) begin
                        state       <= ARB_BUSY_DATA;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.dataWe;
                        mem_addr_q  <= bus.dataAddr;
                        mem_wdata_q <= bus.dataWdata;
                    end else if (grant_if) begin
                        state      <= ARB_BUSY_IF;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= bus.ifAddr;
                    end
                end
                // A redirected fetch still runs to completion on the bus; only its result is dropped.
                ARB_BUSY_IF: begin
                    if (bus.memAck) begin
                        state     <= ARB_IDLE;
                        mem_req_q <= 1'b0;
                        flush_q   <= 1'b0;
                        if (!(flush_q || bus.ifFlush)) begin
                            if_instr_q <= bus.memRdata;
                            if_valid_q <= 1'b1;
                        end
                    end else if (bus.ifFlush) begin
                        flush_q <= 1'b1;
                    end
                end
                ARB_BUSY_DATA: begin
                    if (bus.memAck) begin
                        state        <= ARB_IDLE;
                        mem_req_q    <= 1'b0;
                        data_rdata_q <= bus.memRdata;
                        data_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= ARB_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ifInstr   = if_instr_q;
    assign bus.ifValid   = if_valid_out;
    assign bus.dataRdata = data_rdata_q;
    assign bus.dataValid = data_valid_q;
    assign bus.memReq    = mem_req_q;
    assign bus.memWe     = mem_we_q;
    assign bus.memAddr   = mem_addr_q;
    assign bus.memWdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a request-level model predicts every bus grant
// and every returned word; a separate monitor matches them against the DUT outputs.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int XLEN   = 32;
    localparam int SMAX   = 4;
    localparam int P_IF   = 0;
    localparam int P_DATA = 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } grant_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.XLEN(XLEN)) bus ();

    mem_arbiter #(
        .XLEN      (XLEN),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    grant_t      grantQ[$];
    resp_t       respQ[$];
    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    bit          run = 1'b0;
    int          mode = 0;
    bit          busy = 1'b0;
    int          curPort = P_IF;
    int          lat = 0;
    bit          discard = 1'b0;
    bit          ackDiscarded = 1'b0;
    bit          predValid = 1'b0;
    int          predPort = P_IF;
    int          starve = 0;
    logic [31:0] lastInstr = '0;
    int          ifDone = 0;
    bit          prevReq = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One negedge worth of core agents, bus responder and arbitration prediction.
    task automatic applyStimulus();
        logic ifV;
        logic dV;
        logic ifP;
        logic dP;
        logic [31:0] rd;
        ifV = bus.ifValid;
        dV  = bus.dataValid;

        if (bus.memAck) begin
            bus.memAck = 1'b0;
            busy = 1'b0;
            if (ackDiscarded) checkOutput("flushed fetch keeps ifInstr", bus.ifInstr, lastInstr);
            ackDiscarded = 1'b0;
        end
        if (predValid) begin
            busy = 1'b1;
            curPort = predPort;
            lat = $urandom_range(0, 3);
            discard = 1'b0;
            predValid = 1'b0;
        end

        if (bus.ifReq) begin
            if (ifV) begin
                if ($urandom_range(0, 1) == 1) bus.ifAddr = $urandom & 32'h0000_FFFC;
                else bus.ifReq = 1'b0;
            end else if (mode == 0 && !(busy && curPort == P_IF) && $urandom_range(0, 5) == 0) begin
                bus.ifReq = 1'b0;
            end
        end else if ($urandom_range(0, 99) < 45) begin
            bus.ifReq  = 1'b1;
            bus.ifAddr = $urandom & 32'h0000_FFFC;
        end
        bus.ifFlush = 1'b0;
        if (mode == 0 && busy && curPort == P_IF && !discard && $urandom_range(0, 5) == 0) begin
            bus.ifFlush = 1'b1;
            bus.ifAddr  = $urandom & 32'h0000_FFFC;
            discard     = 1'b1;
        end

        if (mode == 0) begin
            if (bus.dataReq && dV) begin
                if ($urandom_range(0, 3) == 0) bus.dataReq = 1'b0;
                else begin
                    bus.dataWe    = 1'($urandom_range(0, 1));
                    bus.dataAddr  = $urandom & 32'h0003_FFFC;
                    bus.dataWdata = $urandom;
                end
            end else if (!bus.dataReq && $urandom_range(0, 99) < 60) begin
                bus.dataReq   = 1'b1;
                bus.dataWe    = 1'($urandom_range(0, 1));
                bus.dataAddr  = $urandom & 32'h0003_FFFC;
                bus.dataWdata = $urandom;
            end
        end

        if (busy) begin
            if (lat == 0) begin
                rd = $urandom;
                bus.memAck   = 1'b1;
                bus.memRdata = rd;
                if (curPort == P_DATA) begin
                    respQ.push_back('{port: P_DATA, data: rd, cyc: cycle});
                end else if (!discard) begin
                    respQ.push_back('{port: P_IF, data: rd, cyc: cycle});
                    lastInstr = rd;
                end
                ackDiscarded = (curPort == P_IF) && discard;
            end else begin
                lat--;
            end
        end

        // Data wins unless fetch has already been overtaken SMAX times in a row.
        if (!busy) begin
            ifP = bus.ifReq && !ifV;
            dP  = bus.dataReq && !dV;
            if (dP && !(ifP && starve == SMAX)) begin
                grantQ.push_back('{we: bus.dataWe, addr: bus.dataAddr, wdata: bus.dataWdata, cyc: cycle});
                if (ifP && starve < SMAX) starve++;
                predPort  = P_DATA;
                predValid = 1'b1;
            end else if (ifP) begin
                grantQ.push_back('{we: 1'b0, addr: bus.ifAddr, wdata: '0, cyc: cycle});
                starve    = 0;
                predPort  = P_IF;
                predValid = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        grant_t g;
        resp_t  r;
        #1;
        if (run) begin
            if (bus.memReq && !prevReq) begin
                if (grantQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected grant: got addr %h expected no grant", bus.memAddr);
                end else begin
                    g = grantQ.pop_front();
                    checkOutput("grant memAddr", bus.memAddr, g.addr);
                    checkOutput("grant memWe", 32'(bus.memWe), 32'(g.we));
                    if (g.we) checkOutput("grant memWdata", bus.memWdata, g.wdata);
                end
            end else if (grantQ.size() > 0 && cycle > grantQ[0].cyc) begin
                g = grantQ.pop_front();
                total++;
                bad++;
                $display("[TB] FAIL missing grant: got memReq %b expected grant to addr %h", bus.memReq, g.addr);
            end

            if (bus.ifValid && bus.dataValid) begin
                total++;
                bad++;
                $display("[TB] FAIL both valids: got ifValid=1 dataValid=1 expected at most one");
            end else if (bus.ifValid || bus.dataValid) begin
                if (bus.ifValid) ifDone++;
                if (respQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected valid: got ifValid=%b dataValid=%b expected none",
                             bus.ifValid, bus.dataValid);
                end else begin
                    r = respQ.pop_front();
                    checkOutput("valid port", bus.dataValid ? P_DATA : P_IF, r.port);
                    checkOutput("returned word", bus.dataValid ? bus.dataRdata : bus.ifInstr, r.data);
                end
            end else if (respQ.size() > 0 && cycle > respQ[0].cyc) begin
                r = respQ.pop_front();
                total++;
                bad++;
                $display("[TB] FAIL missing valid: got none expected port %0d word %h", r.port, r.data);
            end
        end
        prevReq = bus.memReq;
    end

    initial begin
        bit found;
        bus.ifReq = 0; bus.ifAddr = 0; bus.ifFlush = 0;
        bus.dataReq = 0; bus.dataWe = 0; bus.dataAddr = 0; bus.dataWdata = 0;
        bus.memRdata = 0; bus.memAck = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset memReq", bus.memReq, 0);
        checkOutput("reset memWe", bus.memWe, 0);
        checkOutput("reset memAddr", bus.memAddr, 0);
        checkOutput("reset ifValid", bus.ifValid, 0);
        checkOutput("reset dataValid", bus.dataValid, 0);
        checkOutput("reset ifInstr", bus.ifInstr, 0);
        checkOutput("reset dataRdata", bus.dataRdata, 0);
        rst_n = 1'b1;

        @(negedge clk);
        bus.ifReq = 1; bus.ifAddr = 32'h100;
        @(negedge clk);
        checkOutput("fetch memReq", bus.memReq, 1);
        checkOutput("fetch memAddr", bus.memAddr, 32'h100);
        checkOutput("fetch memWe", bus.memWe, 0);
        @(negedge clk);
        checkOutput("fetch memReq held", bus.memReq, 1);
        bus.memAck = 1; bus.memRdata = 32'h0050_0093;
        @(negedge clk);
        bus.memAck = 0;
        checkOutput("fetch ifValid", bus.ifValid, 1);
        checkOutput("fetch ifInstr", bus.ifInstr, 32'h0050_0093);
        checkOutput("fetch memReq released", bus.memReq, 0);
        bus.ifReq = 0;
        @(negedge clk);
        checkOutput("fetch ifValid one cycle", bus.ifValid, 0);

        bus.ifReq = 1; bus.ifAddr = 32'h104;
        bus.dataReq = 1; bus.dataWe = 1; bus.dataAddr = 32'h2000; bus.dataWdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("store first memWe", bus.memWe, 1);
        checkOutput("store first memAddr", bus.memAddr, 32'h2000);
        checkOutput("store first memWdata", bus.memWdata, 32'hDEAD_BEEF);
        bus.memAck = 1; bus.memRdata = 32'h1234_5678;
        @(negedge clk);
        bus.memAck = 0;
        checkOutput("store dataValid", bus.dataValid, 1);
        checkOutput("store no ifValid", bus.ifValid, 0);
        bus.dataReq = 0; bus.dataWe = 0;
        @(negedge clk);
        checkOutput("fetch after store memReq", bus.memReq, 1);
        checkOutput("fetch after store memAddr", bus.memAddr, 32'h104);
        checkOutput("fetch after store memWe", bus.memWe, 0);
        bus.memAck = 1; bus.memRdata = 32'h00A0_0113;
        @(negedge clk);
        bus.memAck = 0;
        checkOutput("fetch after store ifInstr", bus.ifInstr, 32'h00A0_0113);
        bus.ifReq = 0;
        @(negedge clk);
        lastInstr = 32'h00A0_0113;

        mode = 0;
        run = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            applyStimulus();
        end

        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            applyStimulus();
            if (busy && curPort == P_DATA && !bus.memAck && bus.memReq) found = 1'b1;
        end
        run = 1'b0;
        if (!found) begin
            total++;
            bad++;
            $display("[TB] FAIL reset setup: got no data transaction expected one within 2000 cycles");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset memReq", bus.memReq, 0);
        checkOutput("async reset memAddr", bus.memAddr, 0);
        checkOutput("async reset ifValid", bus.ifValid, 0);
        checkOutput("async reset dataValid", bus.dataValid, 0);
        grantQ.delete();
        respQ.delete();
        busy = 0; predValid = 0; starve = 0; discard = 0; ackDiscarded = 0; lastInstr = '0;
        bus.ifReq = 0; bus.ifFlush = 0; bus.dataReq = 0; bus.dataWe = 0; bus.memAck = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        mode = 1;
        ifDone = 0;
        run = 1'b1;
        repeat (60) begin
            @(negedge clk);
            applyStimulus();
        end
        @(negedge clk);
        run = 1'b0;
        checkOutput("fetch completes after reset", 32'(ifDone > 0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
